// File: rtl/timer_access_sequencer_pkg.sv
// Shared definitions for the timer access sequencer: timer register map,
// control bits, command/state encodings and bus helpers.
package timer_seq_pkg;
  localparam int TMR_AW = 3;
  localparam int TMR_DW = 16;

  localparam logic [TMR_AW-1:0] ADDR_STATUS   = 3'd0;
  localparam logic [TMR_AW-1:0] ADDR_CONTROL  = 3'd1;
  localparam logic [TMR_AW-1:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [TMR_AW-1:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [TMR_AW-1:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [TMR_AW-1:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_SNAP = 2'b01,
    CMD_STOP = 2'b10,
    CMD_ACK  = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_PL, S_LD_PH, S_LD_CTL,
    S_SN_WR, S_SN_RL, S_SN_RH, S_SN_CAP,
    S_STOP_WR, S_ACK_WR, S_DONE
  } state_e;

  typedef struct packed {
    logic              cs;
    logic              wn;
    logic [TMR_AW-1:0] addr;
    logic [TMR_DW-1:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, wn: 1'b1, addr: '0, wdata: '0};

  function automatic bus_t bus_wr(input logic [TMR_AW-1:0] a, input logic [TMR_DW-1:0] d);
    return '{cs: 1'b1, wn: 1'b0, addr: a, wdata: d};
  endfunction

  function automatic bus_t bus_rd(input logic [TMR_AW-1:0] a);
    return '{cs: 1'b1, wn: 1'b1, addr: a, wdata: '0};
  endfunction

  function automatic logic [TMR_DW-1:0] ctl_word(input logic stop, input logic start,
                                                  input logic cont, input logic ito);
    logic [TMR_DW-1:0] w;
    w            = '0;
    w[CTL_STOP]  = stop;
    w[CTL_START] = start;
    w[CTL_CONT]  = cont;
    w[CTL_ITO]   = ito;
    return w;
  endfunction
endpackage

// File: rtl/timer_access_sequencer_if.sv
// Avalon-MM link between the sequencer (master) and the interval timer s1 port.
interface timer_access_sequencer_if;
  import timer_seq_pkg::*;
  logic [TMR_AW-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [TMR_DW-1:0] writedata;
  logic [TMR_DW-1:0] readdata;
  logic              irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/timer_access_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr wins.
module rr_arbiter
  import timer_seq_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid
);
  int idx;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/timer_access_sequencer.sv
// Shares one Avalon interval timer among N_REQ requesters: arbitrates, expands
// commands into 16-bit register sequences, and steers the irq to the owner.
module timer_access_sequencer
  import timer_seq_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0][1:0]   cmd,
  input  logic [N_REQ-1:0][31:0]  period,
  input  logic [N_REQ-1:0]        cont,
  input  logic [N_REQ-1:0]        ie,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic [31:0]             snap_value,
  output logic [N_REQ-1:0]        timeout,
  timer_access_sequencer_if.master tmr
);
  logic [N_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic [1:0]       g_cmd;
  logic [31:0]      g_per;
  logic             g_cont, g_ie;

  state_e           state_q, state_d;
  bus_t             bus_q, bus_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [15:0]      per_hi_q, per_hi_d;
  logic             cont_q, cont_d, ie_q, ie_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic             owner_valid_q, owner_valid_d;
  logic             sh_cont_q, sh_cont_d, sh_ie_q, sh_ie_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [31:0]      snap_q, snap_d;
  logic [15:0]      snap_lo_q, snap_lo_d;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .grant      (gnt_oh),
    .grant_id   (gnt_id),
    .grant_valid(gnt_vld)
  );

  // One-hot AND-OR select of the granted requester's operands.
  always_comb begin
    g_cmd  = '0;
    g_per  = '0;
    g_cont = 1'b0;
    g_ie   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      g_cmd  = g_cmd  | (cmd[i]    & {2{gnt_oh[i]}});
      g_per  = g_per  | (period[i] & {32{gnt_oh[i]}});
      g_cont = g_cont | (cont[i]   & gnt_oh[i]);
      g_ie   = g_ie   | (ie[i]     & gnt_oh[i]);
    end
  end

  // bus_d is what the timer sees next cycle, so every access is registered.
  always_comb begin
    state_d       = state_q;
    bus_d         = BUS_IDLE;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    per_hi_d      = per_hi_q;
    cont_d        = cont_q;
    ie_d          = ie_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    sh_cont_d     = sh_cont_q;
    sh_ie_d       = sh_ie_q;
    done_d        = 1'b0;
    snap_d        = snap_q;
    snap_lo_d     = snap_lo_q;
    unique case (state_q)
      S_IDLE: if (gnt_vld) begin
        ptr_d    = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        gid_d    = gnt_id;
        per_hi_d = g_per[31:16];
        cont_d   = g_cont;
        ie_d     = g_ie;
        unique case (cmd_e'(g_cmd))
          CMD_LOAD: begin state_d = S_LD_PL;   bus_d = bus_wr(ADDR_PERIOD_L, g_per[15:0]); end
          CMD_SNAP: begin state_d = S_SN_WR;   bus_d = bus_wr(ADDR_SNAP_L, '0); end
          CMD_STOP: begin
            state_d = S_STOP_WR;
            bus_d   = bus_wr(ADDR_CONTROL, ctl_word(1'b1, 1'b0, sh_cont_q, sh_ie_q));
          end
          CMD_ACK:  begin state_d = S_ACK_WR;  bus_d = bus_wr(ADDR_STATUS, '0); end
          default:  state_d = S_IDLE;
        endcase
      end
      S_LD_PL: begin state_d = S_LD_PH; bus_d = bus_wr(ADDR_PERIOD_H, per_hi_q); end
      S_LD_PH: begin
        // Ownership moves together with the control write that starts the timer.
        state_d       = S_LD_CTL;
        bus_d         = bus_wr(ADDR_CONTROL, ctl_word(1'b0, 1'b1, cont_q, ie_q));
        owner_d       = gid_q;
        owner_valid_d = 1'b1;
        sh_cont_d     = cont_q;
        sh_ie_d       = ie_q;
      end
      S_LD_CTL:  begin state_d = S_DONE; done_d = 1'b1; end
      S_SN_WR:   begin state_d = S_SN_RL; bus_d = bus_rd(ADDR_SNAP_L); end
      S_SN_RL:   begin state_d = S_SN_RH; bus_d = bus_rd(ADDR_SNAP_H); end
      S_SN_RH:   begin state_d = S_SN_CAP; snap_lo_d = tmr.readdata; end
      S_SN_CAP:  begin state_d = S_DONE; snap_d = {tmr.readdata, snap_lo_q}; done_d = 1'b1; end
      S_STOP_WR: begin state_d = S_DONE; owner_valid_d = 1'b0; done_d = 1'b1; end
      S_ACK_WR:  begin state_d = S_DONE; done_d = 1'b1; end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    done_id_d = done_d ? gid_q : done_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      bus_q         <= BUS_IDLE;
      ptr_q         <= '0;
      gid_q         <= '0;
      per_hi_q      <= '0;
      cont_q        <= 1'b0;
      ie_q          <= 1'b0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      sh_cont_q     <= 1'b0;
      sh_ie_q       <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      snap_q        <= '0;
      snap_lo_q     <= '0;
    end else begin
      state_q       <= state_d;
      bus_q         <= bus_d;
      ptr_q         <= ptr_d;
      gid_q         <= gid_d;
      per_hi_q      <= per_hi_d;
      cont_q        <= cont_d;
      ie_q          <= ie_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      sh_cont_q     <= sh_cont_d;
      sh_ie_q       <= sh_ie_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      snap_q        <= snap_d;
      snap_lo_q     <= snap_lo_d;
    end
  end

  always_comb begin
    timeout = '0;
    for (int i = 0; i < N_REQ; i++)
      timeout[i] = tmr.irq & owner_valid_q & (owner_q == ID_W'(i));
  end

  assign tmr.address    = bus_q.addr;
  assign tmr.chipselect = bus_q.cs;
  assign tmr.write_n    = bus_q.wn;
  assign tmr.writedata  = bus_q.wdata;
  assign done           = done_q;
  assign done_id        = done_id_q;
  assign snap_value     = snap_q;
endmodule

// File: tb/tb_timer_access_sequencer.sv
// Directed + randomized bench for timer_access_sequencer against a
// transaction-level model of the expected timer accesses and completions.
module tb_timer_access_sequencer;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][1:0]   cmd = '0;
  logic [N-1:0][31:0]  period = '0;
  logic [N-1:0]        cont = '0, ie = '0;
  logic                done;
  logic [1:0]          done_id;
  logic [31:0]         snap_value;
  logic [N-1:0]        timeout;

  timer_access_sequencer_if tmr ();

  timer_access_sequencer #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .cmd(cmd), .period(period),
    .cont(cont), .ie(ie), .done(done), .done_id(done_id),
    .snap_value(snap_value), .timeout(timeout), .tmr(tmr)
  );

  always #5 clk = ~clk;

  // Timer slave model: snapshot on snap_l write, registered readdata.
  logic [31:0] tmr_cnt = 32'h0, snap_reg = 32'h0;
  always @(posedge clk) begin
    if (tmr.chipselect && !tmr.write_n && tmr.address == 3'd4) snap_reg <= tmr_cnt;
    if (tmr.chipselect && tmr.write_n)
      tmr.readdata <= (tmr.address == 3'd4) ? snap_reg[15:0] :
                      (tmr.address == 3'd5) ? snap_reg[31:16] : 16'h0;
    else
      tmr.readdata <= 16'h0;
  end

  typedef struct packed { logic [15:0] cyc; logic wn; logic [2:0] a; logic [15:0] d; } acc_t;
  typedef struct packed { logic [15:0] cyc; logic [1:0] id; logic [31:0] snap; } dn_t;

  acc_t obs_acc[$], exp_acc[$];
  dn_t  obs_dn[$], exp_dn[$];
  int   cyc = 0, checks = 0, errors = 0;
  int   m_ptr = 0, m_owner = 0;
  bit   m_ov = 0, m_cont = 0, m_ie = 0;
  logic [31:0] m_snap = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input int c, input logic wn, input logic [2:0] a, input logic [15:0] d);
    acc_t r;
    r.cyc = 16'(c); r.wn = wn; r.a = a; r.d = d;
    return r;
  endfunction

  // Advance one cycle and sample away from the edge; a requester drops req on its done.
  task automatic tick();
    @(posedge clk); #1; cyc++;
    if (tmr.chipselect) obs_acc.push_back(mk(cyc, tmr.write_n, tmr.address, tmr.writedata));
    else chk("bus_idle", 64'({tmr.write_n, tmr.address, tmr.writedata}), 64'h80000);
    if (done) begin
      obs_dn.push_back('{cyc: 16'(cyc), id: done_id, snap: snap_value});
      req[done_id] = 1'b0;
    end
  endtask

  // Reference: serve the mask round-robin, emitting each command's access table.
  task automatic build_exp(input logic [N-1:0] mask, input int t0);
    int t, id, td, j;
    logic [N-1:0] m;
    t = t0; m = mask;
    while (m != 0) begin
      id = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (id < 0 && m[j]) id = j;
      end
      m[id] = 1'b0;
      m_ptr = (id + 1) % N;
      case (cmd[id])
        2'd0: begin
          exp_acc.push_back(mk(t+1, 1'b0, 3'd2, period[id][15:0]));
          exp_acc.push_back(mk(t+2, 1'b0, 3'd3, period[id][31:16]));
          exp_acc.push_back(mk(t+3, 1'b0, 3'd1, 16'(4 + 2*int'(cont[id]) + int'(ie[id]))));
          m_owner = id; m_ov = 1; m_cont = cont[id]; m_ie = ie[id];
          td = t + 4;
        end
        2'd1: begin
          exp_acc.push_back(mk(t+1, 1'b0, 3'd4, 16'h0));
          exp_acc.push_back(mk(t+2, 1'b1, 3'd4, 16'h0));
          exp_acc.push_back(mk(t+3, 1'b1, 3'd5, 16'h0));
          m_snap = tmr_cnt;
          td = t + 5;
        end
        2'd2: begin
          exp_acc.push_back(mk(t+1, 1'b0, 3'd1, 16'(8 + 2*int'(m_cont) + int'(m_ie))));
          m_ov = 0;
          td = t + 2;
        end
        default: begin
          exp_acc.push_back(mk(t+1, 1'b0, 3'd0, 16'h0));
          td = t + 2;
        end
      endcase
      exp_dn.push_back('{cyc: 16'(td), id: 2'(id), snap: m_snap});
      t = td + 1;
    end
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    int n;
    obs_acc.delete(); exp_acc.delete(); obs_dn.delete(); exp_dn.delete();
    build_exp(mask, cyc);
    req = mask;
    n = 0;
    while (req != 0 && n < 60) begin tick(); n++; end
    chk("batch_drain", 64'(n < 60), 64'h1);
    tick();
    chk("n_acc", 64'(obs_acc.size()), 64'(exp_acc.size()));
    for (int i = 0; i < obs_acc.size() && i < exp_acc.size(); i++)
      chk($sformatf("acc%0d", i), 64'(obs_acc[i]), 64'(exp_acc[i]));
    chk("n_done", 64'(obs_dn.size()), 64'(exp_dn.size()));
    for (int i = 0; i < obs_dn.size() && i < exp_dn.size(); i++)
      chk($sformatf("done%0d", i), 64'(obs_dn[i]), 64'(exp_dn[i]));
  endtask

  task automatic chk_timeout(input logic irq);
    logic [N-1:0] e;
    tmr.irq = irq; #1;
    e = (irq && m_ov) ? N'(1 << m_owner) : '0;
    chk("timeout", 64'(timeout), 64'(e));
    tmr.irq = 1'b0; #1;
  endtask

  initial begin
    tmr.irq = 1'b0;
    repeat (3) tick();
    chk("rst_outs", 64'({done, done_id, snap_value, tmr.chipselect, tmr.write_n, tmr.address, tmr.writedata}),
        64'({1'b0, 2'b0, 32'h0, 1'b0, 1'b1, 3'b0, 16'h0}));
    chk_timeout(1'b1);
    reset_n = 1'b1;
    tick();

    // LOAD from requester 1, then irq goes to it
    cmd[1] = 2'd0; period[1] = 32'h0001_86A0; cont[1] = 1'b1; ie[1] = 1'b1;
    run_batch(4'b0010);
    chk_timeout(1'b1);

    // SNAP with the timer counter at 0x1234
    tmr_cnt = 32'h0000_1234; cmd[1] = 2'd1;
    run_batch(4'b0010);
    chk("snap_val", 64'(snap_value), 64'h1234);

    // Pointer to 1, then 0/2/3 together -> 2,3,0; non-owner ACK from 3 keeps owner
    cmd = '1;
    run_batch(4'b0001);
    run_batch(4'b1101);
    chk_timeout(1'b1);
    run_batch(4'b1111);

    // LOAD cont=1 ie=0 by requester 2, then STOP -> control 0x000A, no timeout
    cmd[2] = 2'd0; period[2] = 32'hDEAD_BEEF; cont[2] = 1'b1; ie[2] = 1'b0;
    run_batch(4'b0100);
    cmd[2] = 2'd2;
    run_batch(4'b0100);
    chk_timeout(1'b1);

    // Reset in the middle of a SNAP, at T+3
    cmd[0] = 2'd1; req = 4'b0001;
    repeat (3) tick();
    reset_n = 1'b0; #1;
    chk("rst_mid", 64'({tmr.chipselect, tmr.write_n, done, tmr.address}), 64'({1'b0, 1'b1, 1'b0, 3'b0}));
    req = '0;
    m_ptr = 0; m_ov = 0; m_cont = 0; m_ie = 0; m_snap = 32'h0;
    tick(); tick();
    chk("rst_snap", 64'(snap_value), 64'h0);
    reset_n = 1'b1;
    tick();
    cmd = '1;
    run_batch(4'b1111);

    // Randomized batches against the model
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < N; i++) begin
        cmd[i]    = 2'($urandom_range(0, 3));
        period[i] = $urandom;
        cont[i]   = 1'($urandom_range(0, 1));
        ie[i]     = 1'($urandom_range(0, 1));
      end
      tmr_cnt = $urandom;
      run_batch(N'($urandom_range(1, 15)));
      chk_timeout(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_access_sequencer.md
Name: timer_access_sequencer

Overview:
- Avalon-MM master that shares one 16-bit interval-timer slave among N_REQ hardware requesters.
- Arbitrates round-robin and turns each 32-bit command (LOAD, SNAP, STOP, ACK) into the timer's sequence of 16-bit register accesses.
- Tracks which requester owns the running timer and routes the timer irq to that requester only.
- Sits between the requesting hardware blocks and the timer s1 port, in place of software drivers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req  in  N_REQ  level request per requester; held until its done pulse
- cmd  in  2*N_REQ  per requester: 00 LOAD, 01 SNAP, 10 STOP, 11 ACK
- period  in  32*N_REQ  per-requester LOAD period value
- cont  in  N_REQ  per-requester LOAD continuous flag
- ie  in  N_REQ  per-requester LOAD interrupt-enable flag
- done  out  1  one-cycle completion pulse
- done_id  out  ID_W  index of the completed requester
- snap_value  out  32  SNAP result; valid with done
- timeout  out  N_REQ  tmr_irq routed to the current owner
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data
- tmr_irq  in  1  timer interrupt

Behaviour:
- Timer register map: 0 status (write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Timer slave has no waitrequest. A write takes effect on the cycle it is presented. Readdata is registered: address presented in cycle T, data valid in T+1.
- Reset values: all outputs 0 except tmr_write_n=1. State IDLE, rr pointer 0, owner_valid=0, shadow cont/ie=0.
- Arbitration happens only in IDLE. Round-robin starts at the pointer; on grant, pointer becomes grant+1 mod N_REQ. The granted cmd/period/cont/ie are latched into grant_id/op registers.
- Bus idle values: chipselect=0, write_n=1, address=0, writedata=0.
- FSM: IDLE -> op states -> DONE -> IDLE. Grant in IDLE at cycle T.
- LOAD: T+1 write addr2 = period[15:0]; T+2 write addr3 = period[31:16]; T+3 write addr1 = {STOP=0, START=1, cont, ie}; T+4 DONE.
  - Back-to-back writes are legal: START in T+3 overrides the timer's force-reload stop.
  - Side effects: owner=grant_id, owner_valid=1, shadow cont/ie updated.
- SNAP: T+1 write addr4 (data 0); T+2 read addr4; T+3 read addr5 and capture low half; T+4 bus idle, capture high half; T+5 DONE with snap_value.
- STOP: T+1 write addr1 = {1,0,shadow cont,shadow ie}; T+2 DONE; owner_valid=0.
- ACK: T+1 write addr0 = 0; T+2 DONE. Any requester may ACK.
- DONE: done=1 and done_id=grant_id for exactly one cycle. snap_value holds until the next SNAP completes. Re-arbitration occurs in the following cycle.
- Requesters deassert req in the cycle after done. A still-asserted req is treated as a new request.
- timeout[i] = tmr_irq & owner_valid & (owner==i). Combinational; no latency.
- A LOAD from a different requester transfers ownership at the LOAD control write.
- req changes mid-operation are ignored; latched operands are used.
- Reset asserted mid-operation aborts the access sequence immediately and returns all outputs to reset values. Timer state is not restored.
- Throughput: one command per 3–6 cycles. No pipelining across commands.

Decomposition:
- Package timer_seq_pkg holds:
  - register address constants (STATUS, CONTROL, PERIOD_L/H, SNAP_L/H);
  - control bit positions;
  - cmd encoding enum;
  - FSM state enum.
- Sub-module rr_arbiter (N_REQ param): inputs req and ptr; outputs one-hot grant and grant index. Purely combinational. The pointer register lives in the parent.

Test Plan:
- Requester 1 LOAD period=0x0001_86A0, cont=1, ie=1 -> writes addr2=0x86A0 @T+1, addr3=0x0001 @T+2, addr1=0x0007 @T+3; done, done_id=1 @T+4; later tmr_irq=1 -> timeout=4'b0010.
- SNAP with timer model counter at 0x0000_1234 -> addr4 write @T+1, reads addr4 @T+2, addr5 @T+3; done @T+5 with snap_value=0x0000_1234.
- Requesters 0, 2, 3 assert simultaneously with pointer=1 -> served in order 2, 3, 0; pointer ends at 1.
- STOP after LOAD (cont=1, ie=0) -> addr1 write 0x000A, owner_valid=0; tmr_irq=1 -> timeout=0.
- ACK from non-owner 3 -> addr0 write, done_id=3; owner unchanged.
- reset_n low during SNAP at T+3 -> chipselect=0, write_n=1, done=0 immediately; after release, pointer=0 and IDLE.
